fetch_prefetch_unit: RTL

Parametrised instruction-fetch stage with a prefetch queue, the successor of the single-register PC fetch stage. It owns the fetch PC, issues one-outstanding request/acknowledge reads to instruction SRAM, buffers returned words with their PCs in a FIFO of configurable depth, and presents the head entry to the IF/ID pipeline register. Branch redirects and boot mode flush the queue and discard any in-flight read, so memory latency is tolerated without corrupting instruction order.

---
 rtl/fetch_prefetch_unit_if.sv | 25 ++
 rtl/fetch_prefetch_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction SRAM read port shared by the fetch unit (master) and the
// instruction memory (slave): one-outstanding request/acknowledge protocol.
interface fetch_prefetch_unit_if #(
    parameter int PC_DATA_WIDTH     = 20,
    parameter int INSTRUCTION_WIDTH = 32
);
    logic                         inst_mem_req_out;
    logic [PC_DATA_WIDTH-1:0]     inst_mem_addr_out;
    logic                         inst_mem_ack_in;
    logic [INSTRUCTION_WIDTH-1:0] inst_mem_data_in;

    modport master (
        output inst_mem_req_out,
        output inst_mem_addr_out,
        input  inst_mem_ack_in,
        input  inst_mem_data_in
    );

    modport slave (
        input  inst_mem_req_out,
        input  inst_mem_addr_out,
        output inst_mem_ack_in,
        output inst_mem_data_in
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a prefetch queue. Owns the fetch PC, keeps at
// most one SRAM read in flight, buffers returned words with their PCs in a
// FIFO and presents the head entry to decode. Redirects and boot mode flush
// the queue and drop any in-flight read so instruction order is preserved.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   -> misaligned redirect targets pulse fetch_fault_out and are
//                rounded down to a PC_STEP boundary
//   undefined -> targets used unchanged, fetch_fault_out tied low
module fetch_prefetch_unit #(
    parameter int                       PC_DATA_WIDTH      = 20,
    parameter int                       INSTRUCTION_WIDTH  = 32,
    parameter logic [PC_DATA_WIDTH-1:0] PC_INITIAL_ADDRESS = '0,
    parameter int                       PC_STEP            = 4,
    parameter int                       FIFO_DEPTH         = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         boot_mode,
    input  logic                         stall,
    input  logic                         select_new_pc_in,
    input  logic [PC_DATA_WIDTH-1:0]     new_pc_in,
    fetch_prefetch_unit_if.master        mem,
    output logic                         inst_valid_out,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
    output logic [PC_DATA_WIDTH-1:0]     pc_out,
    output logic                         fetch_fault_out
);

    localparam int                       PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                       CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]         DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PC_DATA_WIDTH-1:0] STEP_C  = PC_DATA_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t                       state;
    logic [PC_DATA_WIDTH-1:0]     fetch_pc;
    logic [PTR_W-1:0]             rd_ptr;
    logic [PTR_W-1:0]             wr_ptr;
    logic [CNT_W-1:0]             count;
    logic [INSTRUCTION_WIDTH-1:0] inst_q [FIFO_DEPTH];
    logic [PC_DATA_WIDTH-1:0]     pc_q   [FIFO_DEPTH];

    logic                         redirect;
    logic                         ack_accept;
    logic                         push;
    logic                         pop;
    logic                         issue;
    logic [PC_DATA_WIDTH-1:0]     redirect_pc;
    logic [PC_DATA_WIDTH-1:0]     pc_after_ack;
    logic [CNT_W-1:0]             count_next;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [PC_DATA_WIDTH-1:0] LOW_MASK = PC_DATA_WIDTH'(PC_STEP - 1);
    logic misaligned;
    assign misaligned = (new_pc_in & LOW_MASK) != '0;
`endif

    // Per-edge decisions: redirect target, FIFO push/pop, next occupancy and issue
    always_comb begin
        redirect   = boot_mode | select_new_pc_in;
        // an ack only counts while a request is actually outstanding
        ack_accept = mem.inst_mem_req_out & mem.inst_mem_ack_in;
        push       = ack_accept & (state == WAIT) & ~redirect;
        pop        = inst_valid_out & ~stall & ~redirect;

        if (boot_mode) begin
            redirect_pc = PC_INITIAL_ADDRESS;
        end else begin
`ifdef FETCH_MISALIGN_CHK_EN
            redirect_pc = new_pc_in & ~LOW_MASK;
`else
            redirect_pc = new_pc_in;
`endif
        end

        pc_after_ack = push ? fetch_pc + STEP_C : fetch_pc;

        count_next = count;
        if (redirect) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end

        // a new read needs the port free (idle or completing now) and a
        // guaranteed FIFO slot for its result
        issue = ~redirect
              & (~mem.inst_mem_req_out | ack_accept)
              & (count_next < DEPTH_C);
    end

    // Fetch FSM: owns request/address registers, fetch PC and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            mem.inst_mem_req_out  <= 1'b0;
            mem.inst_mem_addr_out <= PC_INITIAL_ADDRESS;
            fetch_pc              <= PC_INITIAL_ADDRESS;
        end else begin
            fetch_pc <= redirect ? redirect_pc : pc_after_ack;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state                 <= WAIT;
                        mem.inst_mem_req_out  <= 1'b1;
                        mem.inst_mem_addr_out <= pc_after_ack;
                    end
                end
                WAIT, DISCARD: begin
                    if (ack_accept) begin
                        if (issue) begin
                            state                 <= WAIT;
                            mem.inst_mem_addr_out <= pc_after_ack;
                        end else begin
                            state                <= IDLE;
                            mem.inst_mem_req_out <= 1'b0;
                        end
                    end else if (redirect) begin
                        // read still in flight: let it finish, drop its data
                        state <= DISCARD;
                    end
                end
                default: begin
                    state                <= IDLE;
                    mem.inst_mem_req_out <= 1'b0;
                end
            endcase
        end
    end

    // Prefetch queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Prefetch queue storage; contents are qualified by count so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            inst_q[wr_ptr] <= mem.inst_mem_data_in;
            pc_q[wr_ptr]   <= mem.inst_mem_addr_out;
        end
    end

    assign inst_valid_out  = (count != '0);
    assign instruction_out = inst_valid_out ? inst_q[rd_ptr] : '0;
    assign pc_out          = inst_valid_out ? pc_q[rd_ptr]   : '0;

`ifdef FETCH_MISALIGN_CHK_EN
    // One-cycle fault pulse for a misaligned branch/jump target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_fault_out <= 1'b0;
        end else begin
            fetch_fault_out <= select_new_pc_in & ~boot_mode & misaligned;
        end
    end
`else
    assign fetch_fault_out = 1'b0;
`endif

endmodule
